alu_sweep_checker: RTL and testbench

ALU_SWEEP_CHECKER -- requirements
Module: alu_sweep_checker

---
 rtl/alu_sweep_if.sv | 12 +
 rtl/alu_sweep_checker.sv | 170 +++++++++++++++++
 tb/tb_alu_sweep_checker.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_sweep_if.sv
// ALU-facing bundle: the checker drives the vector select and opcode, and the ALU
// returns its result and flags.
interface alu_sweep_if;
    logic [2:0]  AB_SW;
    logic [2:0]  ALU_OP;
    logic [31:0] F;
    logic        ZF;
    logic        OF;

    modport master (output AB_SW, output ALU_OP, input F, input ZF, input OF);
    modport slave  (input AB_SW, input ALU_OP, output F, output ZF, output OF);
endinterface

// File: rtl/alu_sweep_checker.sv
// Walks all 64 {preset, opcode} vectors through an external ALU. Each vector settles
// for SETTLE cycles and is then compared on all 34 bits against a built-in golden model.
module alu_sweep_checker #(
    parameter int unsigned SETTLE = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    alu_sweep_if.master        alu,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [6:0]         err_cnt,
    output logic [5:0]         first_fail,
    output logic               first_fail_vld
);
    localparam int unsigned IDX_W = 6;
    localparam int unsigned CNT_W = 4;
    localparam int unsigned ERR_W = 7;
    localparam int unsigned VEC_W = 34;

    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(63);
    localparam logic [ERR_W-1:0] ERR_MAX   = ERR_W'(64);
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(SETTLE - 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_CHECK, S_DONE} state_e;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               pass_q, pass_d;
    logic [ERR_W-1:0]   err_q, err_d;
    logic [IDX_W-1:0]   ff_q, ff_d;
    logic               ffv_q, ffv_d;
    logic               mismatch_c;

    // Golden result {ZF, OF, F} for one vector index.
    function automatic logic [VEC_W-1:0] expected_vec(input logic [IDX_W-1:0] idx);
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] f;
        logic        of;
        case (idx[5:3])
            3'd0:    begin a = 32'h0000_0000; b = 32'h0000_0000; end
            3'd1:    begin a = 32'h0000_0003; b = 32'h0000_0607; end
            3'd2:    begin a = 32'h8000_0000; b = 32'h8000_0000; end
            3'd3:    begin a = 32'h7FFF_FFFF; b = 32'h7FFF_FFFF; end
            3'd4:    begin a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; end
            3'd5:    begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            3'd6:    begin a = 32'hFFFF_FFFF; b = 32'h8000_0000; end
            default: begin a = 32'h1234_5678; b = 32'h3333_3333; end
        endcase
        of = 1'b0;
        case (idx[2:0])
            3'd0:    f = a & b;
            3'd1:    f = a | b;
            3'd2:    f = a ^ b;
            3'd3:    f = ~(a | b);
            3'd4:    begin f = a + b; of = (a[31] == b[31]) && (f[31] != a[31]); end
            3'd5:    begin f = a - b; of = (a[31] != b[31]) && (f[31] != a[31]); end
            3'd6:    f = {31'd0, ($signed(a) < $signed(b))};
            default: f = b << a[4:0];
        endcase
        return {(f == 32'd0), of, f};
    endfunction

    assign mismatch_c = ({alu.ZF, alu.OF, alu.F} != expected_vec(idx_q));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= '0;
            ff_q    <= '0;
            ffv_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            err_q   <= err_d;
            ff_q    <= ff_d;
            ffv_q   <= ffv_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = done_q;
        err_d   = err_q;
        ff_d    = ff_q;
        ffv_d   = ffv_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_WAIT;
                    idx_d   = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    err_d   = '0;
                    ff_d    = '0;
                    ffv_d   = 1'b0;
                end
            end
            S_WAIT: begin
                if (abort) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b0;
                end else if (cnt_q == WAIT_LAST) begin
                    state_d = S_CHECK;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_CHECK: begin
                if (abort) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b0;
                end else begin
                    if (mismatch_c) begin
                        if (err_q != ERR_MAX) begin
                            err_d = err_q + ERR_W'(1);
                        end
                        if (!ffv_q) begin
                            ff_d  = idx_q;
                            ffv_d = 1'b1;
                        end
                    end
                    if (idx_q == IDX_LAST) begin
                        state_d = S_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                        idx_d   = idx_q + IDX_W'(1);
                        cnt_d   = '0;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        pass_d = done_d && (err_d == '0);
    end

    assign alu.AB_SW      = idx_q[5:3];
    assign alu.ALU_OP     = idx_q[2:0];
    assign busy           = busy_q;
    assign done           = done_q;
    assign pass           = pass_q;
    assign err_cnt        = err_q;
    assign first_fail     = ff_q;
    assign first_fail_vld = ffv_q;
endmodule

// File: tb/tb_alu_sweep_checker.sv
// Scoreboard bench for alu_sweep_checker: a faultable ALU model answers the sweep,
// expected sweep outcomes are queued at start and checked when busy drops.
module tb_alu_sweep_checker;
    localparam int SETTLE = 2;
    localparam int VLEN   = SETTLE + 1;

    typedef struct packed {
        logic [31:0] busy_len;
        logic        done;
        logic        pass;
        logic [6:0]  err;
        logic [5:0]  ff;
        logic        ffv;
        logic [5:0]  vec;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst, start, abort;
    logic        busy, done, pass, first_fail_vld;
    logic [6:0]  err_cnt;
    logic [5:0]  first_fail;

    int          fault_mode;
    logic [63:0] rnd_mask;
    int          rnd_bit [64];
    logic [5:0]  alu_idx;
    logic [33:0] alu_vec;

    exp_t        exp_q [$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          events_pushed = 0;
    int          events_done = 0;

    alu_sweep_if alu_if ();

    alu_sweep_checker #(.SETTLE(SETTLE)) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .abort          (abort),
        .alu            (alu_if),
        .busy           (busy),
        .done           (done),
        .pass           (pass),
        .err_cnt        (err_cnt),
        .first_fail     (first_fail),
        .first_fail_vld (first_fail_vld)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference ALU {ZF, OF, F}: signed arithmetic done in 64 bits, overflow = out of 32-bit range.
    function automatic logic [33:0] golden(input logic [5:0] idx);
        logic [31:0] a, b, f;
        longint      sa, sb, s;
        logic        of;
        case (idx[5:3])
            3'd0: begin a = 32'h0;          b = 32'h0;          end
            3'd1: begin a = 32'd3;          b = 32'h607;        end
            3'd2: begin a = 32'h80000000;   b = 32'h80000000;   end
            3'd3: begin a = 32'h7FFFFFFF;   b = 32'h7FFFFFFF;   end
            3'd4: begin a = 32'hFFFFFFFF;   b = 32'hFFFFFFFF;   end
            3'd5: begin a = 32'h80000000;   b = 32'hFFFFFFFF;   end
            3'd6: begin a = 32'hFFFFFFFF;   b = 32'h80000000;   end
            default: begin a = 32'h12345678; b = 32'h33333333; end
        endcase
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        s  = 0;
        of = 1'b0;
        case (idx[2:0])
            3'd0: f = a & b;
            3'd1: f = a | b;
            3'd2: f = a ^ b;
            3'd3: f = ~(a | b);
            3'd4: s = sa + sb;
            3'd5: s = sa - sb;
            3'd6: f = (sa < sb) ? 32'd1 : 32'd0;
            default: f = b << a[4:0];
        endcase
        if (idx[2:0] == 3'd4 || idx[2:0] == 3'd5) begin
            f  = s[31:0];
            of = (s > 64'sd2147483647) || (s < -64'sd2147483648);
        end
        return {(f == 32'd0), of, f};
    endfunction

    // Bits the faulty ALU flips relative to golden for a given vector.
    function automatic logic [33:0] fault_mask(input int md, input logic [5:0] idx,
                                               input logic rm, input int rb);
        logic [33:0] g;
        g = golden(idx);
        case (md)
            1: return (idx[2:0] == 3'd4) ? 34'd1 : 34'd0;
            2: return g[33] ? (34'd1 << 33) : 34'd0;
            3: return (idx == 6'd3) ? 34'd1 : 34'd0;
            4: return rm ? (34'd1 << rb) : 34'd0;
            default: return 34'd0;
        endcase
    endfunction

    always_comb begin
        alu_idx = {alu_if.AB_SW, alu_if.ALU_OP};
        alu_vec = golden(alu_idx) ^ fault_mask(fault_mode, alu_idx, rnd_mask[alu_idx], rnd_bit[alu_idx]);
        alu_if.ZF = alu_vec[33];
        alu_if.OF = alu_vec[32];
        alu_if.F  = alu_vec[31:0];
    end

    // Monitor: tracks each busy window, checks vector pacing, scores the outcome when busy falls.
    initial begin : monitor
        int   blen;
        int   seq_bad;
        bit   in_sweep;
        exp_t e;
        blen = 0; seq_bad = 0; in_sweep = 0;
        forever begin
            @(negedge clk);
            if (busy === 1'b1) begin
                if ({alu_if.AB_SW, alu_if.ALU_OP} !== 6'(blen / VLEN)) seq_bad++;
                blen++;
                in_sweep = 1;
            end else if (in_sweep) begin
                in_sweep = 0;
                if (exp_q.size() == 0) begin
                    chk("unexpected_sweep_end", 64'(exp_q.size()), 64'd1);
                end else begin
                    e = exp_q.pop_front();
                    chk("busy_cycles",    64'(blen),           64'(e.busy_len));
                    chk("done",           64'(done),           64'(e.done));
                    chk("pass",           64'(pass),           64'(e.pass));
                    chk("err_cnt",        64'(err_cnt),        64'(e.err));
                    chk("first_fail",     64'(first_fail),     64'(e.ff));
                    chk("first_fail_vld", 64'(first_fail_vld), 64'(e.ffv));
                    chk("held_vector",    64'({alu_if.AB_SW, alu_if.ALU_OP}), 64'(e.vec));
                    chk("vector_pacing",  64'(seq_bad),        64'd0);
                end
                blen = 0;
                seq_bad = 0;
                events_done++;
            end
        end
    end

    // One sweep: stop_at>0 aborts (or resets) at that cycle after start; restart_at pulses start mid-sweep.
    task automatic do_sweep(input int md, input int stop_at, input bit stop_rst,
                            input int restart_at, input bit abort_with_start);
        exp_t e;
        int   n;
        int   guard;
        logic [33:0] fm;
        e = '0;
        fault_mode = md;
        if (stop_rst) begin
            e.busy_len = 32'(stop_at);
        end else begin
            n = (stop_at == 0) ? 64 : (stop_at - 1) / VLEN;
            for (int i = 0; i < n; i++) begin
                fm = fault_mask(md, 6'(i), rnd_mask[i], rnd_bit[i]);
                if (fm != 34'd0) begin
                    if (!e.ffv) begin e.ff = 6'(i); e.ffv = 1'b1; end
                    e.err = e.err + 7'd1;
                end
            end
            e.busy_len = (stop_at == 0) ? 32'(64 * VLEN) : 32'(stop_at);
            e.done     = (stop_at == 0);
            e.pass     = e.done && (e.err == 7'd0);
            e.vec      = (stop_at == 0) ? 6'd63 : 6'(n);
        end
        exp_q.push_back(e);
        events_pushed++;

        @(negedge clk);
        start = 1'b1;
        abort = abort_with_start;
        for (int c = 1; c < 200; c++) begin
            @(negedge clk);
            start = (c == restart_at);
            abort = !stop_rst && (c == stop_at);
            rst   = stop_rst && (c == stop_at);
        end
        start = 1'b0; abort = 1'b0; rst = 1'b0;

        guard = 0;
        while (events_done != events_pushed && guard < 400) begin
            @(negedge clk);
            guard++;
        end
        chk("sweep_end_seen", 64'(events_done), 64'(events_pushed));

        if (e.done) begin
            repeat (6) @(negedge clk);
            chk("done_held",    64'(done),    64'd1);
            chk("pass_held",    64'(pass),    64'(e.pass));
            chk("err_cnt_held", 64'(err_cnt), 64'(e.err));
        end
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        rst = 1'b1; start = 1'b0; abort = 1'b0;
        fault_mode = 0;
        rnd_mask = '0;
        for (int i = 0; i < 64; i++) rnd_bit[i] = 0;

        repeat (3) @(negedge clk);
        chk("rst_busy",           64'(busy),           64'd0);
        chk("rst_done",           64'(done),           64'd0);
        chk("rst_pass",           64'(pass),           64'd0);
        chk("rst_err_cnt",        64'(err_cnt),        64'd0);
        chk("rst_first_fail",     64'(first_fail),     64'd0);
        chk("rst_first_fail_vld", 64'(first_fail_vld), 64'd0);
        chk("rst_ab_sw",          64'(alu_if.AB_SW),   64'd0);
        chk("rst_alu_op",         64'(alu_if.ALU_OP),  64'd0);

        // rst beats start; abort alone in IDLE does nothing
        start = 1'b1;
        @(negedge clk);
        rst = 1'b0; start = 1'b0; abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("rst_over_start_busy", 64'(busy), 64'd0);
        chk("idle_abort_done",     64'(done), 64'd0);

        do_sweep(0, 0,   1'b0, 0,  1'b0);   // golden ALU
        do_sweep(1, 0,   1'b0, 0,  1'b0);   // ADD result bit 0 flipped
        do_sweep(2, 0,   1'b0, 0,  1'b0);   // ZF stuck at 0
        do_sweep(0, 0,   1'b0, 50, 1'b0);   // start ignored mid-sweep
        do_sweep(0, 100, 1'b1, 0,  1'b0);   // reset mid-sweep
        do_sweep(0, 0,   1'b0, 0,  1'b0);   // clean sweep after reset
        do_sweep(3, 31,  1'b0, 0,  1'b0);   // abort during vector 10, error at 3
        do_sweep(0, 0,   1'b0, 0,  1'b1);   // start wins over abort in IDLE
        do_sweep(3, 0,   1'b0, 0,  1'b1);   // start wins over abort in DONE

        for (int r = 0; r < 6; r++) begin
            int stop;
            rnd_mask = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
            for (int i = 0; i < 64; i++) rnd_bit[i] = int'($urandom_range(33, 0));
            stop = ($urandom_range(2, 0) == 0) ? int'($urandom_range(191, 1)) : 0;
            do_sweep(4, stop, 1'b0, 0, 1'b0);
        end

        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
